// File: rtl/clause_ctrl_pkg.sv
// clause_ctrl_pkg: shared controller state encoding and read-FIFO depth
// Contents: state_t (IDLE/LOAD/READ/FIN), FIFO_DEPTH (rows the read skid can hold)
package clause_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, READ, FIN} state_t;
    localparam int FIFO_DEPTH = 2;
endpackage

// File: rtl/clause_rd_skid.sv
// clause_rd_skid: 2-entry read-side FIFO with fall-through when empty
// Ports: clka/reset; in_valid/in_ready/in_data/in_last (from BRAM return);
//        out_valid/out_ready/out_data/out_last (read stream); occ = stored rows
module clause_rd_skid
    import clause_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 256
) (
    input  logic                  clka,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic                  in_last,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic                  out_last,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic [1:0]            occ
);
    logic [DATA_WIDTH:0] mem [FIFO_DEPTH];
    logic                rp, wp, push, pop, store, take;
    logic [1:0]          cnt;

    // an arriving row bypasses storage when the FIFO is empty and is taken at once
    always_comb begin
        occ       = cnt;
        in_ready  = cnt < 2'(FIFO_DEPTH);
        out_valid = cnt != 2'd0 || in_valid;
        {out_last, out_data} = cnt != 2'd0 ? mem[rp] : in_valid ? {in_last, in_data} : '0;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        store     = push && !(cnt == 2'd0 && pop);
        take      = pop && cnt != 2'd0;
    end

    always_ff @(posedge clka or posedge reset) begin
        if (reset) begin
            mem <= '{default: '0};
            rp  <= 1'b0;
            wp  <= 1'b0;
            cnt <= 2'd0;
        end else begin
            if (store) begin
                mem[wp] <= {in_last, in_data};
                wp      <= ~wp;
            end
            if (take) rp <= ~rp;
            cnt <= cnt + 2'(store) - 2'(take);
        end
    end
endmodule

// File: rtl/clause_bram_ctrl.sv
// clause_bram_ctrl: load/read pass controller for the clause dual-port BRAM
// Ports: clka/reset; cfg_num_rows, load_start, rd_start (pass control);
//        ld_valid/ld_ready/ld_data (load stream); out_valid/out_ready/out_data/out_last
//        (read stream); busy, done; ram_ena/wea/addra/dina (write port),
//        ram_enb/addrb/doutb (read port, one-cycle read latency)
module clause_bram_ctrl
    import clause_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 256
) (
    input  logic                  clka,
    input  logic                  reset,
    input  logic [ADDR_WIDTH:0]   cfg_num_rows,
    input  logic                  load_start,
    input  logic                  rd_start,
    input  logic                  ld_valid,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic                  ld_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_ena,
    output logic                  ram_wea,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [DATA_WIDTH-1:0] ram_dina,
    output logic                  ram_enb,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    input  logic [DATA_WIDTH-1:0] ram_doutb
);
    state_t              state;
    logic [ADDR_WIDTH:0] n, cnt, cnt_inc;
    logic                inflight, inflight_last, acc, issue, fin_rd, skid_ready;
    logic [1:0]          occ;

    // reads are issued only while stored plus in-flight rows leave room in the skid
    always_comb begin
        cnt_inc   = cnt + (ADDR_WIDTH+1)'(1);
        ld_ready  = state == LOAD;
        acc       = ld_ready && ld_valid;
        ram_ena   = acc;
        ram_wea   = acc;
        ram_addra = acc ? cnt[ADDR_WIDTH-1:0] : '0;
        ram_dina  = acc ? ld_data : '0;
        issue     = state == READ && skid_ready && cnt < n &&
                    ({1'b0, occ} + {2'b0, inflight}) < 3'(FIFO_DEPTH);
        ram_enb   = issue;
        ram_addrb = issue ? cnt[ADDR_WIDTH-1:0] : '0;
        fin_rd    = out_valid && out_ready && out_last;
        busy      = state != IDLE;
        done      = state == FIN;
    end

    always_ff @(posedge clka or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            n             <= '0;
            cnt           <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue && cnt_inc == n;
            case (state)
                IDLE: if (load_start || rd_start) begin
                    n     <= cfg_num_rows;
                    cnt   <= '0;
                    state <= cfg_num_rows == '0 ? FIN : load_start ? LOAD : READ;
                end
                LOAD: if (acc) begin
                    cnt <= cnt_inc;
                    if (cnt_inc == n) state <= FIN;
                end
                READ: begin
                    if (issue) cnt <= cnt_inc;
                    if (fin_rd) state <= FIN;
                end
                FIN: state <= IDLE;
            endcase
        end
    end

    clause_rd_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
        .clka      (clka),
        .reset     (reset),
        .in_valid  (inflight),
        .in_last   (inflight_last),
        .in_data   (ram_doutb),
        .in_ready  (skid_ready),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_data  (out_data),
        .out_ready (out_ready),
        .occ       (occ)
    );
endmodule
